// File: rtl/mem_preloader_if.sv
// mem_preloader_if: stream-in, write-out and status bus of the program/data loader
// master: stream source plus memory/regfile sink and core-control observer
// slave:  the loader (in_ready, write strobe and status are driven by it)
interface mem_preloader_if #(
   parameter int XLEN = 32,
   parameter int AW   = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_data;
   logic            wr_en;
   logic [1:0]      wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            cpu_rst;
   logic            done;
   logic            err;
   logic [15:0]     words_loaded;
   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_sel, wr_addr, wr_data, cpu_rst, done, err, words_loaded
   );
   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_sel, wr_addr, wr_data, cpu_rst, done, err, words_loaded
   );
endinterface

// File: rtl/mem_preloader.sv
// mem_preloader: streams sectioned records into imem/dmem/regfile writes and holds the core in reset until RUN
// Ports: clk; rst (asynchronous, active high); bus (slave modport):
//   in_valid/in_ready/in_data  record word stream (header, base, N data words; RUN is header only)
//   wr_en/wr_sel/wr_addr/wr_data  one-cycle write strobe (sel 0 imem, 1 dmem, 2 regfile)
//   cpu_rst/done/err/words_loaded  core reset, sticky RUN seen, sticky dropped-write flag, saturating write count
module mem_preloader #(
   parameter int XLEN       = 32,
   parameter int IMEM_BYTES = 1024,
   parameter int DMEM_BYTES = 1024,
   parameter int NREGS      = 32,
   parameter int AW         = 16
) (
   input logic            clk,
   input logic            rst,
   mem_preloader_if.slave bus
);
   typedef enum logic [1:0] {HDR, BASE, DATA, RUN} state_t;
   localparam logic [32:0] isz = 33'(IMEM_BYTES);
   localparam logic [32:0] dsz = 33'(DMEM_BYTES);
   state_t          state;
   logic [1:0]      tgt;
   logic [15:0]     cnt;
   logic [31:0]     addr;
   logic [XLEN-1:0] word;
   logic            acc;
   logic            is_reg;
   logic            in_range;
   logic            keep;
   logic [32:0]     last;
   always_comb begin
      word     = bus.in_data;
      acc      = bus.in_valid && bus.in_ready;
      is_reg   = tgt == 2'd2;
      // 33-bit so the top byte of a word near 2^32 cannot wrap back into range
      last     = {1'b0, addr} + 33'd3;
      in_range = is_reg ? addr < 32'(NREGS)
                        : addr[1:0] == 2'b00 && last < (tgt == 2'd0 ? isz : dsz);
      // x0 is hard-wired zero: drop its write without flagging an error
      keep     = in_range && !(is_reg && addr == 32'd0);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state            <= HDR;
         tgt              <= '0;
         cnt              <= '0;
         addr             <= '0;
         bus.in_ready     <= 1'b0;
         bus.wr_en        <= 1'b0;
         bus.wr_sel       <= '0;
         bus.wr_addr      <= '0;
         bus.wr_data      <= '0;
         bus.cpu_rst      <= 1'b1;
         bus.done         <= 1'b0;
         bus.err          <= 1'b0;
         bus.words_loaded <= '0;
      end else begin
         bus.wr_en    <= 1'b0;
         bus.in_ready <= state != RUN;
         if (acc)
            case (state)
               HDR:
                  if (word[31:30] == 2'd3) begin
                     state        <= RUN;
                     bus.in_ready <= 1'b0;
                     bus.cpu_rst  <= 1'b0;
                     bus.done     <= 1'b1;
                  end else begin
                     tgt   <= word[31:30];
                     cnt   <= word[15:0];
                     state <= BASE;
                  end
               BASE: begin
                  addr  <= word[31:0];
                  state <= cnt == 16'd0 ? HDR : DATA;
               end
               DATA: begin
                  if (keep) begin
                     bus.wr_en        <= 1'b1;
                     bus.wr_sel       <= tgt;
                     bus.wr_addr      <= addr[AW-1:0];
                     bus.wr_data      <= word;
                     bus.words_loaded <= bus.words_loaded == 16'hFFFF ? 16'hFFFF : bus.words_loaded + 16'd1;
                  end else if (!in_range)
                     bus.err <= 1'b1;
                  addr <= addr + (is_reg ? 32'd1 : 32'd4);
                  cnt  <= cnt - 16'd1;
                  if (cnt == 16'd1)
                     state <= HDR;
               end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_mem_preloader.sv
// tb_mem_preloader: directed self-checking bench for mem_preloader
module tb_mem_preloader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   typedef struct {
      logic [1:0]  s;
      logic [15:0] a;
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t log_q[$];
   mem_preloader_if bus ();
   mem_preloader dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (bus.wr_en) log_q.push_back('{bus.wr_sel, bus.wr_addr, bus.wr_data, cyc});
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [31:0] d, input int gap = 0);
      @(negedge clk);
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            bus.in_data = $urandom;
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int t = 0; !bus.in_ready && t < 50; t++) @(negedge clk);
      if (!bus.in_ready) check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
   endtask
   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
   endtask
   task automatic expect_wr(input string tag, input int i, input logic [1:0] s,
                            input logic [15:0] a, input logic [31:0] d);
      if (i < log_q.size()) begin
         check({tag, "_sel"}, {30'd0, log_q[i].s}, {30'd0, s});
         check({tag, "_addr"}, {16'd0, log_q[i].a}, {16'd0, a});
         check({tag, "_data"}, log_q[i].d, d);
      end else
         check({tag, "_missing"}, log_q.size(), i + 1);
   endtask
   initial begin
      int bad;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      check("rst_addr_data", {16'd0, bus.wr_addr} | bus.wr_data | {30'd0, bus.wr_sel}, 32'd0);
      check("rst_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
      check("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
      check("rst_words", {16'd0, bus.words_loaded}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
      // imem program then RUN
      send(32'h0000_0002);
      send(32'h0000_0000);
      send(32'h0010_0093);
      send(32'h0020_8433);
      #1 check("t1_not_done", {30'd0, bus.done, bus.cpu_rst}, 32'd1);
      send(32'hC000_0000);
      #1 check("t1_done", {31'd0, bus.done}, 32'd1);
      check("t1_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
      check("t1_ready_run", {31'd0, bus.in_ready}, 32'd0);
      idle();
      check("t1_count", log_q.size(), 2);
      expect_wr("t1_w0", 0, 2'd0, 16'h0000, 32'h0010_0093);
      expect_wr("t1_w1", 1, 2'd0, 16'h0004, 32'h0020_8433);
      if (log_q.size() >= 2) check("t1_b2b", log_q[1].c - log_q[0].c, 1);
      check("t1_words", {16'd0, bus.words_loaded}, 32'd2);
      // regfile load with x0 suppressed
      do_reset();
      send(32'h8000_0003);
      send(32'h0000_0000);
      send(32'h0000_00AA);
      send(32'h0000_0001);
      send(32'hFFFF_FFF0);
      idle();
      @(negedge clk);
      check("t2_count", log_q.size(), 2);
      expect_wr("t2_x1", 0, 2'd2, 16'd1, 32'h0000_0001);
      expect_wr("t2_x2", 1, 2'd2, 16'd2, 32'hFFFF_FFF0);
      check("t2_err", {31'd0, bus.err}, 32'd0);
      check("t2_words", {16'd0, bus.words_loaded}, 32'd2);
      // dmem range check at the top boundary
      do_reset();
      send(32'h4000_0002);
      send(32'h0000_03FC);
      send(32'h1111_1111);
      send(32'h2222_2222);
      idle();
      @(negedge clk);
      check("t3_count", log_q.size(), 1);
      expect_wr("t3_top", 0, 2'd1, 16'h03FC, 32'h1111_1111);
      check("t3_err", {31'd0, bus.err}, 32'd1);
      check("t3_words", {16'd0, bus.words_loaded}, 32'd1);
      // misaligned dmem base
      do_reset();
      send(32'h4000_0001);
      send(32'h0000_0002);
      send(32'h3333_3333);
      idle();
      @(negedge clk);
      check("t3b_count", log_q.size(), 0);
      check("t3b_err", {31'd0, bus.err}, 32'd1);
      check("t3b_words", {16'd0, bus.words_loaded}, 32'd0);
      // gapped stream, then empty record, then RUN
      do_reset();
      send(32'h0000_0002, $urandom_range(0, 3));
      send(32'h0000_0000, $urandom_range(0, 3));
      send(32'h0010_0093, $urandom_range(0, 3));
      send(32'h0020_8433, $urandom_range(0, 3));
      send(32'h4000_0000, $urandom_range(0, 3));
      send(32'h0000_0100, $urandom_range(0, 3));
      send(32'hC000_0000, $urandom_range(0, 3));
      idle();
      @(negedge clk);
      check("t4_count", log_q.size(), 2);
      expect_wr("t4_w0", 0, 2'd0, 16'h0000, 32'h0010_0093);
      expect_wr("t4_w1", 1, 2'd0, 16'h0004, 32'h0020_8433);
      check("t4_done", {31'd0, bus.done}, 32'd1);
      check("t4_words", {16'd0, bus.words_loaded}, 32'd2);
      // asynchronous reset mid-record
      do_reset();
      send(32'h4000_0003);
      send(32'h0000_0010);
      send(32'h0000_0005);
      #1 check("t5_wr_pre", {31'd0, bus.wr_en}, 32'd1);
      #2 rst = 1'b1;
      bus.in_valid = 1'b0;
      #1 check("t5_wr_en", {31'd0, bus.wr_en}, 32'd0);
      check("t5_ready", {31'd0, bus.in_ready}, 32'd0);
      check("t5_addr_data", {16'd0, bus.wr_addr} | bus.wr_data, 32'd0);
      check("t5_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
      check("t5_err", {31'd0, bus.err}, 32'd0);
      check("t5_words", {16'd0, bus.words_loaded}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
      send(32'h4000_0002);
      send(32'h0000_0020);
      send(32'hAAAA_0001);
      send(32'hBBBB_0002);
      send(32'hC000_0000);
      idle();
      check("t5_count", log_q.size(), 2);
      expect_wr("t5_w0", 0, 2'd1, 16'h0020, 32'hAAAA_0001);
      expect_wr("t5_w1", 1, 2'd1, 16'h0024, 32'hBBBB_0002);
      check("t5_done", {31'd0, bus.done}, 32'd1);
      check("t5_words_re", {16'd0, bus.words_loaded}, 32'd2);
      // held in RUN despite valid input
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready || bus.wr_en) bad++;
         bus.in_valid = 1'b1;
         bus.in_data  = $urandom;
      end
      bus.in_valid = 1'b0;
      check("t6_run_hold", bad, 0);
      check("t6_no_writes", log_q.size(), 2);
      check("t6_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
